// File: rtl/isect_rr_arbiter.sv
// isect_rr_arbiter: round-robin front end for a shared, non-stalling
// triangle/ray intersection pipeline with in-order result routing.
module isect_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 16,
  parameter int IDXW    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*288-1:0]  i_req_tri,
  input  logic [NREQ*192-1:0]  i_req_ray,
  input  logic [NREQ*IDXW-1:0] i_req_idx,
  output logic                 o_en,
  output logic [287:0]         o_tri,
  output logic [191:0]         o_ray,
  input  logic [31:0]          i_t,
  input  logic                 i_result,
  input  logic                 i_valid,
  output logic [NREQ-1:0]      o_res_valid,
  output logic [31:0]          o_res_t,
  output logic                 o_res_hit,
  output logic [IDXW-1:0]      o_res_idx,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [GW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   wp_q, wp_d;
  logic [PW-1:0]   rp_q, rp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            en_q, en_d;
  logic [287:0]    tri_q, tri_d;
  logic [191:0]    ray_q, ray_d;
  logic [NREQ-1:0] resv_q, resv_d;
  logic [31:0]     rest_q, rest_d;
  logic            hit_q, hit_d;
  logic [IDXW-1:0] ridx_q, ridx_d;
  logic            err_q, err_d;

  logic [GW-1:0]   tag_mem_q [MAX_OUT];
  logic [IDXW-1:0] idx_mem_q [MAX_OUT];

  logic [GW-1:0]   gnt;
  logic            found;
  logic [GW:0]     cand;
  logic            can_issue;
  logic            hs;
  logic            empty;
  logic            pop;
  logic [IDXW-1:0] sel_idx;

  assign can_issue = (cnt_q < CW'(MAX_OUT));
  assign empty     = (cnt_q == '0);
  assign hs        = found & can_issue;
  assign pop       = i_valid & ~empty;
  assign sel_idx   = i_req_idx[int'(gnt)*IDXW +: IDXW];

  // Rotating priority scan starting at the round-robin pointer.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(NREQ)) cand = cand - (GW+1)'(NREQ);
      if (!found && i_req_valid[cand[GW-1:0]]) begin
        found = 1'b1;
        gnt   = cand[GW-1:0];
      end
    end
  end

  // Only the granted requester sees ready, and only with credit left.
  always_comb begin
    o_req_ready = '0;
    if (hs) o_req_ready[gnt] = 1'b1;
  end

  // Next state: issue register, tag FIFO pointers, result register.
  always_comb begin
    ptr_d  = ptr_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    en_d   = hs;
    tri_d  = tri_q;
    ray_d  = ray_q;
    resv_d = '0;
    rest_d = rest_q;
    hit_d  = hit_q;
    ridx_d = ridx_q;
    err_d  = err_q | (i_valid & empty);
    if (hs) begin
      tri_d = i_req_tri[int'(gnt)*288 +: 288];
      ray_d = i_req_ray[int'(gnt)*192 +: 192];
      if (int'(gnt) == NREQ - 1) ptr_d = '0;
      else                       ptr_d = gnt + GW'(1);
      if (int'(wp_q) == MAX_OUT - 1) wp_d = '0;
      else                           wp_d = wp_q + PW'(1);
    end
    if (pop) begin
      resv_d = NREQ'(1) << tag_mem_q[rp_q];
      rest_d = i_t;
      hit_d  = i_result;
      ridx_d = idx_mem_q[rp_q];
      if (int'(rp_q) == MAX_OUT - 1) rp_d = '0;
      else                           rp_d = rp_q + PW'(1);
    end
    unique case ({hs, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      ptr_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      tri_q  <= '0;
      ray_q  <= '0;
      resv_q <= '0;
      rest_q <= '0;
      hit_q  <= 1'b0;
      ridx_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      tri_q  <= tri_d;
      ray_q  <= ray_d;
      resv_q <= resv_d;
      rest_q <= rest_d;
      hit_q  <= hit_d;
      ridx_q <= ridx_d;
      err_q  <= err_d;
    end
  end

  // Tag FIFO storage; contents are don't-care while empty.
  always_ff @(posedge i_clk) begin
    if (i_rstn && hs) begin
      tag_mem_q[wp_q] <= gnt;
      idx_mem_q[wp_q] <= sel_idx;
    end
  end

  assign o_en        = en_q;
  assign o_tri       = tri_q;
  assign o_ray       = ray_q;
  assign o_res_valid = resv_q;
  assign o_res_t     = rest_q;
  assign o_res_hit   = hit_q;
  assign o_res_idx   = ridx_q;
  assign o_busy      = (cnt_q != '0) | en_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_isect_rr_arbiter.sv
// tb_isect_rr_arbiter: directed and random scoreboard bench for
// isect_rr_arbiter with a fixed-latency, stallable unit model.
module tb_isect_rr_arbiter;
  localparam int N   = 4;
  localparam int MO  = 16;
  localparam int LAT = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn;
  logic [N-1:0]   rv, rdy;
  logic [N*288-1:0] rtri;
  logic [N*192-1:0] rray;
  logic [N*32-1:0]  ridx;
  logic           en;
  logic [287:0]   otri;
  logic [191:0]   oray;
  logic [31:0]    it;
  logic           ires, iv;
  logic [N-1:0]   resv;
  logic [31:0]    rest;
  logic           reshit;
  logic [31:0]    residx;
  logic           busy, err;

  logic [N-1:0]   b_rv, b_rdy;
  logic [N*288-1:0] b_tri;
  logic [N*192-1:0] b_ray;
  logic [N*32-1:0]  b_idx;
  logic           b_en;
  logic [287:0]   b_otri;
  logic [191:0]   b_oray;
  logic [31:0]    b_it;
  logic           b_ires, b_iv;
  logic [N-1:0]   b_resv;
  logic [31:0]    b_rest;
  logic           b_reshit;
  logic [31:0]    b_residx;
  logic           b_busy, b_err;

  isect_rr_arbiter #(.NREQ(N), .MAX_OUT(MO), .IDXW(32)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req_valid(rv), .o_req_ready(rdy),
    .i_req_tri(rtri), .i_req_ray(rray), .i_req_idx(ridx),
    .o_en(en), .o_tri(otri), .o_ray(oray),
    .i_t(it), .i_result(ires), .i_valid(iv),
    .o_res_valid(resv), .o_res_t(rest), .o_res_hit(reshit),
    .o_res_idx(residx), .o_busy(busy), .o_err(err)
  );

  isect_rr_arbiter #(.NREQ(N), .MAX_OUT(4), .IDXW(32)) dut4 (
    .i_clk(clk), .i_rstn(rstn),
    .i_req_valid(b_rv), .o_req_ready(b_rdy),
    .i_req_tri(b_tri), .i_req_ray(b_ray), .i_req_idx(b_idx),
    .o_en(b_en), .o_tri(b_otri), .o_ray(b_oray),
    .i_t(b_it), .i_result(b_ires), .i_valid(b_iv),
    .o_res_valid(b_resv), .o_res_t(b_rest), .o_res_hit(b_reshit),
    .o_res_idx(b_residx), .o_busy(b_busy), .o_err(b_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [287:0] obs,
                     input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          g;
    logic [31:0] idx;
    logic [31:0] t;
    logic        hit;
    int          due;
  } sb_t;

  typedef struct {
    int          due;
    logic [31:0] t;
    logic        hit;
  } u_t;

  sb_t sb[$];
  u_t  uq[$];
  int  glog[$];

  int           ptr_m = 0;
  logic         en_m = 1'b0;
  logic [287:0] tri_m = '0;
  logic [191:0] ray_m = '0;
  logic [N-1:0] resv_m = '0;
  logic [31:0]  rest_m = '0;
  logic         reshit_m = 1'b0;
  logic [31:0]  residx_m = '0;
  logic         err_m = 1'b0;
  int           due_m = -1;

  int cyc = 0;
  bit stall = 0;
  int stall_rel = 1000;
  bit chk_lat = 0;
  int nidx = 1;
  int auto_p = 0;
  int n_iss = 0;
  int n_res = 0;

  task automatic new_req(input int r);
    ridx[r*32 +: 32] = nidx;
    nidx++;
    for (int k = 0; k < 9; k++) rtri[r*288 + k*32 +: 32] = $urandom;
    for (int k = 0; k < 6; k++) rray[r*192 + k*32 +: 32] = $urandom;
  endtask

  task automatic tick();
    int g;
    logic hs;
    logic [N-1:0] rdy_e;
    sb_t e;
    u_t u;
    @(negedge clk);
    chk("en", en, en_m);
    chk("busy", busy, (sb.size() != 0) || en_m);
    chk("err", err, err_m);
    chk("res_valid", resv, resv_m);
    if (resv_m != 0) begin
      chk("res_t", rest, rest_m);
      chk("res_hit", reshit, reshit_m);
      chk("res_idx", residx, residx_m);
      if (due_m >= 0) chk("res_lat", cyc, due_m);
    end
    if (en_m) begin
      chk("tri", otri, tri_m);
      chk("ray", oray, ray_m);
    end
    g = -1;
    for (int i = 0; i < N; i++) begin
      int c;
      c = (ptr_m + i) % N;
      if (g < 0 && rv[c]) g = c;
    end
    rdy_e = '0;
    hs = 1'b0;
    if (g >= 0 && sb.size() < MO) begin
      rdy_e[g] = 1'b1;
      hs = 1'b1;
    end
    chk("ready", rdy, rdy_e);
    if (!rstn) begin
      hs = 1'b0;
      ptr_m = 0;
      sb.delete();
      uq.delete();
      en_m = 1'b0;
      tri_m = '0;
      ray_m = '0;
      resv_m = '0;
      rest_m = '0;
      reshit_m = 1'b0;
      residx_m = '0;
      err_m = 1'b0;
      due_m = -1;
    end else begin
      resv_m = '0;
      due_m = -1;
      if (iv) begin
        if (sb.size() == 0) err_m = 1'b1;
        else begin
          e = sb.pop_front();
          resv_m[e.g] = 1'b1;
          rest_m = e.t;
          reshit_m = e.hit;
          residx_m = e.idx;
          due_m = e.due;
          n_res++;
        end
      end
      en_m = hs;
      if (hs) begin
        tri_m = rtri[g*288 +: 288];
        ray_m = rray[g*192 +: 192];
        e.g = g;
        e.idx = ridx[g*32 +: 32];
        e.t = rtri[g*288 +: 32] ^ rray[g*192 +: 32];
        e.hit = rray[g*192 + 32];
        e.due = chk_lat ? cyc + 2 + LAT : -1;
        sb.push_back(e);
        ptr_m = (g + 1) % N;
        n_iss++;
        glog.push_back(g);
      end
      if (en) begin
        u.due = cyc + LAT;
        u.t = otri[31:0] ^ oray[31:0];
        u.hit = oray[32];
        uq.push_back(u);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (stall && sb.size() >= stall_rel) stall = 0;
    iv = 1'b0;
    if (!stall && uq.size() > 0 && uq[0].due <= cyc) begin
      u = uq.pop_front();
      iv = 1'b1;
      it = u.t;
      ires = u.hit;
    end
    if (hs) begin
      if (auto_p == 1) new_req(g);
      else if (auto_p == 2) begin
        if ($urandom_range(0, 1) == 1) new_req(g);
        else rv[g] = 1'b0;
      end else rv[g] = 1'b0;
    end
    if (auto_p == 2) begin
      for (int r = 0; r < N; r++) begin
        if (!rv[r] && $urandom_range(0, 2) == 0) begin
          new_req(r);
          rv[r] = 1'b1;
        end
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    stall = 0;
    auto_p = 0;
    while ((sb.size() != 0 || uq.size() != 0 || rv != 0 || en_m ||
            resv_m != 0) && k < 400) begin
      tick();
      k++;
    end
    chk("drain_bound", k < 400, 1'b1);
  endtask

  initial begin
    int nacc;
    int k;
    int base;
    rstn = 1'b0;
    rv = '0; rtri = '0; rray = '0; ridx = '0;
    iv = 1'b0; it = '0; ires = 1'b0;
    b_rv = '0; b_tri = '0; b_ray = '0; b_idx = '0;
    b_iv = 1'b0; b_it = '0; b_ires = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // fairness, all four requesters valid, fixed latency
    chk_lat = 1;
    auto_p = 1;
    for (int r = 0; r < N; r++) new_req(r);
    rv = '1;
    glog.delete();
    repeat (40) tick();
    for (int i = 0; i < 8; i++) chk("rr_seq", glog[i], i % 4);
    drain();
    chk_lat = 0;

    // sparse single requester with fixed result values
    new_req(2);
    ridx[2*32 +: 32] = 32'h5;
    rtri[2*288 +: 32] = 32'h00018000;
    rray[2*192 +: 64] = 64'h1_0000_0000;
    rv = 4'b0100;
    #1;
    chk("sp_rdy", rdy, 4'b0100);
    tick();
    chk("sp_en", en, 1'b1);
    for (int j = 0; j < 12; j++) begin
      tick();
      if (resv !== 4'b0000) begin
        chk("sp_v", resv, 4'b0100);
        chk("sp_t", rest, 32'h00018000);
        chk("sp_hit", reshit, 1'b1);
        chk("sp_idx", residx, 32'h5);
        break;
      end
    end
    drain();

    // push and pop together while one credit short of full
    auto_p = 1;
    for (int r = 0; r < N; r++) new_req(r);
    rv = '1;
    stall = 1;
    stall_rel = MO - 1;
    repeat (40) tick();
    #1;
    chk("pp_rdy", |rdy, 1'b1);
    chk("pp_busy", busy, 1'b1);
    stall_rel = 1000;
    drain();

    // random traffic with random unit stalls
    base = n_iss;
    auto_p = 2;
    k = 0;
    while (n_iss < base + 100 && k < 3000) begin
      stall = ($urandom_range(0, 3) == 0);
      tick();
      k++;
    end
    chk("rand_bound", k < 3000, 1'b1);
    drain();
    chk("no_loss", n_res, n_iss);

    // spurious result with nothing in flight
    iv = 1'b1;
    it = 32'hdead;
    tick();
    chk("spur_err", err, 1'b1);
    chk("spur_v", resv, 4'b0000);
    repeat (3) tick();
    chk("spur_sticky", err, 1'b1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // reset with three issues in flight
    for (int r = 0; r < 3; r++) new_req(r);
    rv = 4'b0111;
    repeat (3) tick();
    chk("mid_busy", busy, 1'b1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mr_en", en, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_v", resv, 4'b0000);
    chk("mr_tri", otri, 288'h0);
    new_req(1);
    new_req(2);
    rv = 4'b0110;
    #1;
    chk("mr_gnt", rdy, 4'b0010);
    drain();

    // depth-4 instance: stalled unit fills the tag FIFO
    b_rv = 4'b0001;
    b_idx[31:0] = 32'h100;
    nacc = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      k = int'(b_rdy[0]);
      nacc += k;
      @(posedge clk);
      #1;
      if (k != 0) b_idx[31:0] = b_idx[31:0] + 32'h1;
    end
    chk("ff_acc", nacc, 4);
    @(negedge clk);
    chk("ff_full", b_rdy, 4'b0000);
    @(posedge clk);
    #1;
    b_iv = 1'b1;
    b_it = 32'h1234;
    b_ires = 1'b1;
    @(negedge clk);
    chk("ff_pop_cyc", b_rdy, 4'b0000);
    @(posedge clk);
    #1;
    b_iv = 1'b0;
    @(negedge clk);
    chk("ff_after", b_rdy, 4'b0001);
    chk("ff_res_v", b_resv, 4'b0001);
    chk("ff_res_idx", b_residx, 32'h100);
    chk("ff_res_t", b_rest, 32'h1234);
    chk("ff_err", b_err, 1'b0);
    b_rv = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
